vga_snake_renderer: RTL
=======================

# vga_snake_renderer

Parametrised VGA timing generator and sprite renderer for the Snake display path, sitting between the game-state logic and the VGA DAC pins. It generates sync and data-enable timing for any mode. Per pixel, it paints:

- the play-field border;
- the food box;
- a variable-length snake of up to `SEG_N` segments.

Object positions are captured once per frame, so mid-frame state updates never tear the image. All outputs are registered and mutually aligned.

## Interface
Parameters:
- `H_SYNC` (112): horizontal sync pulse width, pixels.
- `H_BACK` (248): horizontal back porch, pixels.
- `H_ACTIVE` (1280): visible pixels per line.
- `H_FRONT` (48): horizontal front porch, pixels.
- `V_SYNC` (3): vertical sync pulse width, lines.
- `V_BACK` (38): vertical back porch, lines.
- `V_ACTIVE` (1024): visible lines per frame.
- `V_FRONT` (1): vertical front porch, lines.
- `CNT_W` (12): H/V counter width; must hold `H_SYNC+H_BACK+H_ACTIVE+H_FRONT-1`.
- `COORD_W` (11): width of one object coordinate.
- `SEG_N` (20): maximum number of snake segments.
- `HALF` (7): sprite half-size; each sprite is (2·`HALF`+1) square.
- `BORDER_X` (70): left/right border thickness, pixels.
- `BORDER_Y` (62): top/bottom border thickness, pixels.
- `LEN_W` (5): width of `I_snake_len`; must hold `SEG_N`.

Ports. Reset `I_rst_n`, asynchronous, active-low; clock `I_clk`.
- `I_clk` input 1: pixel clock.
- `I_rst_n` input 1: async active-low reset.
- `I_box_x` input `COORD_W`: food box centre x, active-area relative.
- `I_box_y` input `COORD_W`: food box centre y, active-area relative.
- `I_snake_body_x` input `SEG_N*COORD_W`: segment k centre x at bits [k·`COORD_W` +: `COORD_W`]; k=0 is the head.
- `I_snake_body_y` input `SEG_N*COORD_W`: segment centre y, same packing.
- `I_snake_len` input `LEN_W`: number of valid segments; values above `SEG_N` saturate to `SEG_N`.
- `O_red`, `O_green`, `O_blue` output 4 each: pixel colour.
- `O_hs` output 1: horizontal sync, active low.
- `O_vs` output 1: vertical sync, active low.
- `O_de` output 1: data enable, high on visible pixels.
- `O_frame_start` output 1: one-cycle pulse marking pixel (0,0) of the frame.

## Operation
Stage 0, counters:
- `H_cnt` counts 0..`H_TOT`-1 with wrap, where `H_TOT` = sum of the four H parameters.
- `V_cnt` advances when `H_cnt` wraps and itself wraps at `V_TOT`-1.

Timing decode:
- Sync low while `H_cnt` < `H_SYNC` (respectively `V_cnt` < `V_SYNC`).
- Active window uses half-open ranges: `H_cnt` in [`H_SYNC+H_BACK`, `H_SYNC+H_BACK+H_ACTIVE`), same form for V.
- Pixel coordinates: `px = H_cnt − (H_SYNC+H_BACK)`, `py` likewise.

Shadow capture:
- On the cycle `H_cnt`=0 and `V_cnt`=0, all position inputs and the saturated length are copied into shadow registers.
- Rendering uses only the shadow registers.

Stage 1, hit tests, registered:
- An object at (cx, cy) is hit when `px+HALF >= cx`, `px <= cx+HALF`, `py+HALF >= cy` and `py <= cy+HALF`.
- These comparisons are evaluated at `CNT_W+1` bits, so nothing underflows and sprites clip cleanly at the edges.
- Segment k contributes only if k < shadow length.
- The border is hit when `px < BORDER_X`, `px >= H_ACTIVE−BORDER_X`, `py < BORDER_Y`, or `py >= V_ACTIVE−BORDER_Y`.

Stage 2, colour select. Priority, highest first:
- border: white, F/F/F;
- box: yellow, F/F/0;
- head (see Configuration);
- body: cyan, 0/F/F;
- otherwise black.

Blanking: colour is forced to 0 whenever `O_de`=0.

## Timing
- Latency: every output at cycle t reflects the counter state at t−2. Sync, `O_de`, `O_frame_start` and colour are delayed by the same amount.
- Reset values:
  - counters 0;
  - shadow registers 0, so shadow length 0;
  - `O_hs`=1, `O_vs`=1, `O_de`=0, `O_frame_start`=0;
  - colours 0.
- Reset asserted mid-frame forces the reset values asynchronously. After release, counting restarts at (0,0), and the first `O_frame_start` appears 2 cycles after the first clock edge.
- Input changes at any point other than the capture cycle take effect from the next frame.
- An input change on the capture cycle itself is captured.
- Length 0 means no snake is drawn.

## Configuration
- `VGA_HEAD_HILITE_EN` defined: segment 0, when valid, is drawn green (0/F/0), with priority below box and above body.
- `VGA_HEAD_HILITE_EN` undefined: segment 0 is treated exactly as a body segment (cyan).

## Test plan
1. Default parameters, free-running. Required: `O_hs` period 1688 cycles, low for 112; `O_vs` period 1688·1066 cycles, low for 3·1688; `O_de` high for 1280 consecutive cycles per line on 1024 lines per frame; `O_frame_start` exactly once per frame.
2. Box at (100,100), length 0. Required: visible pixels x,y ∈ [93,107] yellow; (92,100) and (108,100) black; (10,500) white.
3. Length 3, segments 0–3 at (200,200), (216,200), (232,200), (248,200). Required: (200,200), (216,200) and (232,200) painted; (248,200) black. With the macro on, (200,200) is green, otherwise cyan.
4. Box at (240,300) overlapping segment 1 at (245,300). Required: pixel (245,300) yellow. Box at (20,20) inside the border: that pixel white.
5. `I_box_x` changed from 100 to 400 at V line 500. Required: current frame still shows the box at 100; next frame shows it at 400. `I_snake_len`=31 with `SEG_N`=20 renders all 20 segments.
6. `I_rst_n` pulsed low mid-line. Required: outputs take reset values without a clock edge; after release, `O_frame_start` pulses 2 cycles after the first edge.

Source files
------------

// File: rtl/vga_snake_renderer_if.sv
// Pixel-side bundle of the snake renderer: object positions in,
// VGA colour/sync/enable out.
interface vga_snake_renderer_if #(
  parameter int COORD_W = 11,
  parameter int SEG_N   = 20,
  parameter int LEN_W   = 5
);
  logic [COORD_W-1:0]       I_box_x;
  logic [COORD_W-1:0]       I_box_y;
  logic [SEG_N*COORD_W-1:0] I_snake_body_x;
  logic [SEG_N*COORD_W-1:0] I_snake_body_y;
  logic [LEN_W-1:0]         I_snake_len;
  logic [3:0]               O_red;
  logic [3:0]               O_green;
  logic [3:0]               O_blue;
  logic                     O_hs;
  logic                     O_vs;
  logic                     O_de;
  logic                     O_frame_start;

  modport master (
    output I_box_x, I_box_y,
    output I_snake_body_x, I_snake_body_y,
    output I_snake_len,
    input  O_red, O_green, O_blue,
    input  O_hs, O_vs, O_de, O_frame_start
  );

  modport slave (
    input  I_box_x, I_box_y,
    input  I_snake_body_x, I_snake_body_y,
    input  I_snake_len,
    output O_red, O_green, O_blue,
    output O_hs, O_vs, O_de, O_frame_start
  );
endinterface

// File: rtl/vga_snake_renderer.sv
// VGA timing + border/box/snake renderer, 2-cycle registered pipeline.
// Define VGA_HEAD_HILITE_EN to draw the snake head green.
module vga_snake_renderer #(
  parameter int H_SYNC   = 112,
  parameter int H_BACK   = 248,
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 48,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 38,
  parameter int V_ACTIVE = 1024,
  parameter int V_FRONT  = 1,
  parameter int CNT_W    = 12,
  parameter int COORD_W  = 11,
  parameter int SEG_N    = 20,
  parameter int HALF     = 7,
  parameter int BORDER_X = 70,
  parameter int BORDER_Y = 62,
  parameter int LEN_W    = 5
) (
  input logic I_clk,
  input logic I_rst_n,
  vga_snake_renderer_if.slave bus
);
  localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ST  = H_SYNC + H_BACK;
  localparam int V_ST  = V_SYNC + V_BACK;
  localparam int XW    = CNT_W + 1;

  typedef enum logic [2:0] {
    C_BLACK,
    C_BORDER,
    C_BOX,
    C_HEAD,
    C_BODY
  } col_e;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOT - 1));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  logic             hs0;
  logic             vs0;
  logic             de0;
  logic             fs0;
  logic [CNT_W-1:0] px;
  logic [CNT_W-1:0] py;

  assign hs0 = (h_cnt >= CNT_W'(H_SYNC));
  assign vs0 = (v_cnt >= CNT_W'(V_SYNC));
  assign de0 = (h_cnt >= CNT_W'(H_ST)) &&
               (h_cnt <  CNT_W'(H_ST + H_ACTIVE)) &&
               (v_cnt >= CNT_W'(V_ST)) &&
               (v_cnt <  CNT_W'(V_ST + V_ACTIVE));
  assign fs0 = (h_cnt == '0) && (v_cnt == '0);
  assign px  = h_cnt - CNT_W'(H_ST);
  assign py  = v_cnt - CNT_W'(V_ST);

  // Positions are latched once per frame so updates never tear.
  logic [COORD_W-1:0]       box_xs;
  logic [COORD_W-1:0]       box_ys;
  logic [SEG_N*COORD_W-1:0] seg_xs;
  logic [SEG_N*COORD_W-1:0] seg_ys;
  logic [LEN_W-1:0]         len_s;
  logic [LEN_W-1:0]         len_sat;

  assign len_sat = (bus.I_snake_len > LEN_W'(SEG_N)) ?
                   LEN_W'(SEG_N) : bus.I_snake_len;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      box_xs <= '0;
      box_ys <= '0;
      seg_xs <= '0;
      seg_ys <= '0;
      len_s  <= '0;
    end else if (fs0) begin
      box_xs <= bus.I_box_x;
      box_ys <= bus.I_box_y;
      seg_xs <= bus.I_snake_body_x;
      seg_ys <= bus.I_snake_body_y;
      len_s  <= len_sat;
    end
  end

  function automatic logic hit(
    input logic [CNT_W-1:0]   x,
    input logic [CNT_W-1:0]   y,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy
  );
    logic [XW-1:0] ex;
    logic [XW-1:0] ey;
    logic [XW-1:0] ecx;
    logic [XW-1:0] ecy;
    ex  = XW'(x);
    ey  = XW'(y);
    ecx = XW'(cx);
    ecy = XW'(cy);
    return (ex + XW'(HALF) >= ecx) && (ex <= ecx + XW'(HALF)) &&
           (ey + XW'(HALF) >= ecy) && (ey <= ecy + XW'(HALF));
  endfunction

  logic border;
  logic box;
  logic head;
  logic body;
  col_e sel;

  always_comb begin
    border = (px <  CNT_W'(BORDER_X)) ||
             (px >= CNT_W'(H_ACTIVE - BORDER_X)) ||
             (py <  CNT_W'(BORDER_Y)) ||
             (py >= CNT_W'(V_ACTIVE - BORDER_Y));
    box  = hit(px, py, box_xs, box_ys);
    head = 1'b0;
    body = 1'b0;
    for (int k = 0; k < SEG_N; k++) begin
      if (k < int'(len_s) &&
          hit(px, py, seg_xs[k*COORD_W +: COORD_W],
              seg_ys[k*COORD_W +: COORD_W])) begin
`ifdef VGA_HEAD_HILITE_EN
        if (k == 0) head = 1'b1;
        else        body = 1'b1;
`else
        body = 1'b1;
`endif
      end
    end
    sel = C_BLACK;
    if (border)    sel = C_BORDER;
    else if (box)  sel = C_BOX;
    else if (head) sel = C_HEAD;
    else if (body) sel = C_BODY;
  end

  logic hs1;
  logic vs1;
  logic de1;
  logic fs1;
  col_e sel1;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      de1  <= 1'b0;
      fs1  <= 1'b0;
      sel1 <= C_BLACK;
    end else begin
      hs1  <= hs0;
      vs1  <= vs0;
      de1  <= de0;
      fs1  <= fs0;
      sel1 <= sel;
    end
  end

  logic [11:0] rgb;

  always_comb begin
    rgb = 12'h000;
    if (de1) begin
      unique case (sel1)
        C_BORDER: rgb = 12'hFFF;
        C_BOX:    rgb = 12'hFF0;
        C_HEAD:   rgb = 12'h0F0;
        C_BODY:   rgb = 12'h0FF;
        default:  rgb = 12'h000;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bus.O_hs          <= 1'b1;
      bus.O_vs          <= 1'b1;
      bus.O_de          <= 1'b0;
      bus.O_frame_start <= 1'b0;
      bus.O_red         <= 4'h0;
      bus.O_green       <= 4'h0;
      bus.O_blue        <= 4'h0;
    end else begin
      bus.O_hs          <= hs1;
      bus.O_vs          <= vs1;
      bus.O_de          <= de1;
      bus.O_frame_start <= fs1;
      bus.O_red         <= rgb[11:8];
      bus.O_green       <= rgb[7:4];
      bus.O_blue        <= rgb[3:0];
    end
  end
endmodule
